// File: rtl/rsp_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsp_collector_pkg
// Description : Shared FSM state encoding and default sizing constants for
//               the response collector and the rwc_ctrl-level top.
// Revision    : 1.0 - initial release
// ============================================================================
package rsp_collector_pkg;

  localparam int DEF_RSP_BITS = 32;    // response word width
  localparam int DEF_WINDOW   = 1024;  // measurement round length (cycles)
  localparam int DEF_CNT_W    = 16;    // edge-counter width
  localparam int TIE_W        = 8;     // tie counter width

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_AVAIL = 3'd1,
    S_MEASURE    = 3'd2,
    S_DECIDE     = 3'd3,
    S_OUTPUT     = 3'd4
  } state_t;

endpackage : rsp_collector_pkg
`default_nettype wire

// File: rtl/rsp_collector_edge_counter.sv
`default_nettype none
// ============================================================================
// Module      : rsp_edge_counter
// Description : Rising-edge detector feeding a saturating counter.
// Ports       : clk, rst (async, active-low)
//               clear     - zero the counter
//               load_hist - load history register with din (no count)
//               enable    - detect/count edges this cycle
//               din       - level input being watched
//               count     - number of 0->1 transitions seen, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module rsp_edge_counter
  import rsp_collector_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load_hist,
  input  logic             enable,
  input  logic             din,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_prev;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev  <= 1'b0;
      r_count <= '0;
    end else begin
      if (clear) begin
        r_count <= '0;
      end else if (enable && din && !r_prev && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end
      // Loading history on entry means a level already high is not an edge.
      if (load_hist || enable) begin
        r_prev <= din;
      end
    end
  end

  assign count = r_count;

endmodule : rsp_edge_counter
`default_nettype wire

// File: rtl/rsp_collector.sv
`default_nettype none
// ============================================================================
// Module      : rsp_collector
// Description : Collects a RSP_BITS-wide response word, one bit per
//               WINDOW-cycle measurement round. Each round compares the
//               number of rsp_write and rsp_clean rising edges; write wins
//               give a 1, otherwise 0 (ties are counted in tie_cnt).
// Ports       : clk, rst (async, active-low)
//               start       - begin a collection (IDLE only)
//               available   - upstream ready; low aborts a running round
//               rsp_write   - write-collision level
//               rsp_clean   - clean-collision level
//               busy        - not IDLE
//               rsp_data    - collected word (LSB first)
//               rsp_valid   - word complete, held until rsp_ready
//               rsp_ready   - consumer accepts the word
//               tie_cnt     - tie-decided rounds, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module rsp_collector
  import rsp_collector_pkg::*;
#(
  parameter int RSP_BITS = DEF_RSP_BITS,
  parameter int WINDOW   = DEF_WINDOW,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                available,
  input  logic                rsp_write,
  input  logic                rsp_clean,
  output logic                busy,
  output logic [RSP_BITS-1:0] rsp_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [TIE_W-1:0]    tie_cnt
);

  localparam int IDX_W = (RSP_BITS > 1) ? $clog2(RSP_BITS) : 1;
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RSP_BITS - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [TIE_W-1:0] TIE_MAX  = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_enter;
  logic                w_count_en;
  logic [IDX_W-1:0]    r_bit_idx;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [RSP_BITS-1:0] r_rsp_data;
  logic [TIE_W-1:0]    r_tie_cnt;
  logic [CNT_W-1:0]    w_write_cnt;
  logic [CNT_W-1:0]    w_clean_cnt;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_WAIT_AVAIL;
      end
      S_WAIT_AVAIL: begin
        if (available) begin
          w_state_nxt = S_MEASURE;
          w_enter     = 1'b1;
        end
      end
      S_MEASURE: begin
        // Losing upstream mid-round discards the round; the bit is retried.
        if (!available)                w_state_nxt = S_WAIT_AVAIL;
        else if (r_win_cnt == WIN_LAST) w_state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        w_state_nxt = (r_bit_idx == IDX_LAST) ? S_OUTPUT : S_WAIT_AVAIL;
      end
      S_OUTPUT: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Edges are counted only in MEASURE cycles that do not abort.
  assign w_count_en = (r_state == S_MEASURE) && available;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_idx  <= '0;
      r_win_cnt  <= '0;
      r_rsp_data <= '0;
      r_tie_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rsp_data <= '0;
            r_bit_idx  <= '0;
            r_tie_cnt  <= '0;
          end
        end
        S_WAIT_AVAIL: begin
          r_win_cnt <= '0;
        end
        S_MEASURE: begin
          if (available) r_win_cnt <= r_win_cnt + WIN_W'(1);
        end
        S_DECIDE: begin
          r_rsp_data[r_bit_idx] <= (w_write_cnt > w_clean_cnt);
          if ((w_write_cnt == w_clean_cnt) && (r_tie_cnt != TIE_MAX)) begin
            r_tie_cnt <= r_tie_cnt + TIE_W'(1);
          end
          if (r_bit_idx != IDX_LAST) r_bit_idx <= r_bit_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Edge counters
  // --------------------------------------------------------------------------
  rsp_edge_counter #(.CNT_W(CNT_W)) u_write_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_enter),
    .load_hist (w_enter),
    .enable    (w_count_en),
    .din       (rsp_write),
    .count     (w_write_cnt)
  );

  rsp_edge_counter #(.CNT_W(CNT_W)) u_clean_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_enter),
    .load_hist (w_enter),
    .enable    (w_count_en),
    .din       (rsp_clean),
    .count     (w_clean_cnt)
  );

  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_OUTPUT);
  assign rsp_data  = r_rsp_data;
  assign tie_cnt   = r_tie_cnt;

endmodule : rsp_collector
`default_nettype wire

// File: tb/tb_rsp_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsp_collector
// Description : Self-checking bench for rsp_collector. Two instances: a
//               4-bit / 16-cycle word with wide counters, and a 2-bit /
//               48-cycle word with 3-bit counters for saturation.
//               Expected words are queued when a collection is launched
//               and compared when rsp_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsp_collector;

  typedef struct {
    logic [31:0] data;
    int          tie;
    int          lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic       available = 1'b1;
  logic       rsp_write = 1'b0;
  logic       rsp_clean = 1'b0;
  logic       rsp_ready = 1'b0;

  logic       busy1, valid1, busy2, valid2;
  logic [3:0] data1;
  logic [1:0] data2;
  logic [7:0] tie1, tie2;

  int          sel = 0;
  logic        cur_valid;
  logic [31:0] cur_data;
  logic [7:0]  cur_tie;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rsp_collector #(.RSP_BITS(4), .WINDOW(16), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .available(available),
    .rsp_write(rsp_write), .rsp_clean(rsp_clean), .busy(busy1),
    .rsp_data(data1), .rsp_valid(valid1), .rsp_ready(rsp_ready),
    .tie_cnt(tie1)
  );

  rsp_collector #(.RSP_BITS(2), .WINDOW(48), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .available(available),
    .rsp_write(rsp_write), .rsp_clean(rsp_clean), .busy(busy2),
    .rsp_data(data2), .rsp_valid(valid2), .rsp_ready(rsp_ready),
    .tie_cnt(tie2)
  );

  assign cur_valid = (sel == 1) ? valid2 : valid1;
  assign cur_data  = (sel == 1) ? 32'(data2) : 32'(data1);
  assign cur_tie   = (sel == 1) ? tie2 : tie1;

  // Launch one collection and compare it against the queued expectation.
  // Pulses sit on odd cycles of each measurement window; the timeline uses
  // WAIT(1) + MEASURE(win) + DECIDE(1) per bit, and an abort in round 1
  // (available low for 5 cycles from the 9th MEASURE cycle) costs 14 cycles.
  task automatic collect(input int s, input int nbits, input int win,
                         input int cntw, input int wp, input int cp,
                         input bit drop, input bit hold_w, input bit rdy_hi);
    exp_t e;
    exp_t got_e;
    int   wc, satv, rel, entry, j, lat, drop_at;
    bit   got;
    logic w_hi, c_hi;
    satv = (1 << cntw) - 1;
    wc   = hold_w ? 0 : ((wp > satv) ? satv : wp);
    e.data = '0;
    e.tie  = 0;
    for (int k = 0; k < nbits; k++) begin
      if (wc > cp)  e.data[k] = 1'b1;
      if (wc == cp) e.tie++;
    end
    e.lat = nbits * (win + 2) + 1 + (drop ? 14 : 0);
    exp_q.push_back(e);

    drop_at   = win + 12;
    sel       = s;
    rel       = 0;
    got       = 1'b0;
    lat       = 0;
    rsp_ready = rdy_hi;
    while (!got && rel < 4000) begin
      @(negedge clk);
      w_hi = hold_w;
      c_hi = 1'b0;
      for (int k = 0; k < nbits; k++) begin
        entry = k * (win + 2) + 1 + ((drop && k >= 1) ? 14 : 0);
        j = rel - entry - 1;
        if (j >= 0 && j < win && (j % 2) == 1) begin
          if (!hold_w && j < 2 * wp) w_hi = 1'b1;
          if (j < 2 * cp)            c_hi = 1'b1;
        end
      end
      rsp_write = w_hi;
      rsp_clean = c_hi;
      available = !(drop && rel >= drop_at && rel < drop_at + 5);
      // Second start pulse lands mid-collection and must be ignored.
      start1 = (s == 0) && (rel == 0 || rel == 40);
      start2 = (s == 1) && (rel == 0 || rel == 40);
      @(posedge clk);
      #1;
      if (cur_valid) begin
        got = 1'b1;
        lat = rel + 1;
      end
      rel++;
    end
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    rsp_write = 1'b0; rsp_clean = 1'b0; available = 1'b1;

    got_e = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL collect_timeout sel=%0d: rsp_valid never seen, required latency %0d", s, got_e.lat);
    end else begin
      checks++;
      if (lat !== got_e.lat) begin
        errors++;
        $display("FAIL latency sel=%0d: got %0d required %0d", s, lat, got_e.lat);
      end
    end
    checks++;
    if (cur_data !== got_e.data) begin
      errors++;
      $display("FAIL rsp_data sel=%0d: got %h required %h", s, cur_data, got_e.data);
    end
    checks++;
    if (int'(cur_tie) !== got_e.tie) begin
      errors++;
      $display("FAIL tie_cnt sel=%0d: got %0d required %0d", s, cur_tie, got_e.tie);
    end
  endtask

  // Accept the pending word and confirm the collector is back in IDLE.
  task automatic handshake(input logic [31:0] exp_data);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (cur_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_after_ready sel=%0d: got %b required 0", sel, cur_valid);
    end
    checks++;
    if (cur_data !== exp_data) begin
      errors++;
      $display("FAIL data_in_idle sel=%0d: got %h required %h", sel, cur_data, exp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy1, valid1, data1, tie1} !== 14'd0) begin
      errors++;
      $display("FAIL reset_dut1: got busy=%b valid=%b data=%h tie=%0d required all 0", busy1, valid1, data1, tie1);
    end
    checks++;
    if ({busy2, valid2, data2, tie2} !== 12'd0) begin
      errors++;
      $display("FAIL reset_dut2: got busy=%b valid=%b data=%h tie=%0d required all 0", busy2, valid2, data2, tie2);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy got %b required 0", busy1);
    end
  endtask

  task automatic test_write_wins();
    collect(0, 4, 16, 16, 5, 2, 1'b0, 1'b0, 1'b0);
    // Word must stay presented while the consumer stalls.
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (valid1 !== 1'b1 || data1 !== 4'hF) begin
        errors++;
        $display("FAIL output_hold: got valid=%b data=%h required 1/f", valid1, data1);
      end
    end
    handshake(32'hF);
  endtask

  task automatic test_ties();
    // rsp_ready held high throughout: ignored until OUTPUT.
    collect(0, 4, 16, 16, 3, 3, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (valid1 !== 1'b0 || tie1 !== 8'd4) begin
      errors++;
      $display("FAIL tie_idle: got valid=%b tie=%0d required 0/4", valid1, tie1);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    collect(0, 4, 16, 16, 5, 2, 1'b1, 1'b0, 1'b0);
    handshake(32'hF);
  endtask

  task automatic test_hold_high();
    collect(0, 4, 16, 16, 0, 1, 1'b0, 1'b1, 1'b0);
    handshake(32'h0);
  endtask

  task automatic test_saturate();
    collect(1, 2, 48, 3, 20, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut2.u_write_cnt.count !== 3'd7) begin
      errors++;
      $display("FAIL write_cnt_sat: got %0d required 7", dut2.u_write_cnt.count);
    end
    handshake(32'h3);
    sel = 0;
  endtask

  task automatic test_reset_output();
    collect(0, 4, 16, 16, 5, 2, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (valid1 !== 1'b0 || data1 !== 4'h0 || busy1 !== 1'b0 || tie1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_in_output: got valid=%b data=%h busy=%b tie=%0d required 0", valid1, data1, busy1, tie1);
    end
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_release: got valid=%b busy=%b required 0/0", valid1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_write_wins();
    test_ties();
    test_abort();
    test_hold_high();
    test_saturate();
    test_reset_output();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_rsp_collector
`default_nettype wire
